// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and the
// read-owner encoding that tags returning read data to its requester.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_WIDTH_DEF  = 12;
  localparam int DMEM_WORD_WIDTH_DEF  = 16;
  localparam int STARVE_LIMIT_DEF     = 4;
  localparam int STARVE_CNT_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_EXT  = 2'd2
  } owner_e;

  // The external read takes precedence because a CPU read only happens when ext lost.
  function automatic owner_e read_owner(input logic cpu_read, input logic ext_read);
    if (ext_read) begin
      return OWNER_EXT;
    end else if (cpu_read) begin
      return OWNER_CPU;
    end
    return OWNER_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between exec, the external requester, the arbiter and the DMEM macro.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dmem_arbiter_if #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16
);

  logic                       in_cpu_rd_en;
  logic                       in_cpu_wr_en;
  logic [DMEM_ADDR_WIDTH-1:0] in_cpu_addr;
  logic [DMEM_WORD_WIDTH-1:0] in_cpu_wr_word;
  logic                       out_cpu_stall;
  logic                       out_cpu_rd_valid;
  logic [DMEM_WORD_WIDTH-1:0] out_cpu_rd_word;

  logic                       in_ext_req;
  logic                       in_ext_we;
  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr;
  logic [DMEM_WORD_WIDTH-1:0] in_ext_wr_word;
  logic                       out_ext_gnt;
  logic                       out_ext_rd_valid;
  logic [DMEM_WORD_WIDTH-1:0] out_ext_rd_word;

  logic                       out_dmem_en;
  logic                       out_dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr;
  logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word;
  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word;

  modport slave (
    input  in_cpu_rd_en, in_cpu_wr_en, in_cpu_addr, in_cpu_wr_word,
    output out_cpu_stall, out_cpu_rd_valid, out_cpu_rd_word,
    input  in_ext_req, in_ext_we, in_ext_addr, in_ext_wr_word,
    output out_ext_gnt, out_ext_rd_valid, out_ext_rd_word,
    output out_dmem_en, out_dmem_we, out_dmem_addr, out_dmem_wr_word,
    input  in_dmem_rd_word
  );

  modport master (
    output in_cpu_rd_en, in_cpu_wr_en, in_cpu_addr, in_cpu_wr_word,
    input  out_cpu_stall, out_cpu_rd_valid, out_cpu_rd_word,
    output in_ext_req, in_ext_we, in_ext_addr, in_ext_wr_word,
    input  out_ext_gnt, out_ext_rd_valid, out_ext_rd_word,
    input  out_dmem_en, out_dmem_we, out_dmem_addr, out_dmem_wr_word,
    output in_dmem_rd_word
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: exec has priority, a starvation counter forces an
// external slot, and 1-cycle read data is steered back to whoever issued the read.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH  = DMEM_ADDR_WIDTH_DEF,
  parameter int DMEM_WORD_WIDTH  = DMEM_WORD_WIDTH_DEF,
  parameter int STARVE_LIMIT     = STARVE_LIMIT_DEF,
  parameter int STARVE_CNT_WIDTH = STARVE_CNT_WIDTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_C = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic                        cpu_act;
  logic                        ext_win;
  logic                        dmem_en;
  logic                        dmem_we;
  logic [DMEM_ADDR_WIDTH-1:0]  dmem_addr;
  logic [DMEM_WORD_WIDTH-1:0]  dmem_wr_word;
  logic [STARVE_CNT_WIDTH-1:0] starve_q, starve_d;
  owner_e                      owner_q, owner_d;

  // Grant decision and memory-side mux; a simultaneous rd+wr from exec is a write.
  always_comb begin
    cpu_act      = bus.in_cpu_rd_en | bus.in_cpu_wr_en;
    ext_win      = bus.in_ext_req & (~cpu_act | (starve_q == LIMIT_C));
    dmem_en      = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wr_word = '0;
    if (ext_win) begin
      dmem_en      = 1'b1;
      dmem_we      = bus.in_ext_we;
      dmem_addr    = bus.in_ext_addr;
      dmem_wr_word = bus.in_ext_wr_word;
    end else if (cpu_act) begin
      dmem_en      = 1'b1;
      dmem_we      = bus.in_cpu_wr_en;
      dmem_addr    = bus.in_cpu_addr;
      dmem_wr_word = bus.in_cpu_wr_word;
    end
  end

  assign bus.out_dmem_en      = dmem_en;
  assign bus.out_dmem_we      = dmem_we;
  assign bus.out_dmem_addr    = dmem_addr;
  assign bus.out_dmem_wr_word = dmem_wr_word;
  assign bus.out_ext_gnt      = ext_win;
  assign bus.out_cpu_stall    = cpu_act & ext_win;

  // Owner records who read this cycle; the counter tracks consecutive ext losses.
  always_comb begin
    owner_d  = read_owner(~ext_win & bus.in_cpu_rd_en & ~bus.in_cpu_wr_en,
                          ext_win & ~bus.in_ext_we);
    starve_d = '0;
    if (bus.in_ext_req && !ext_win) begin
      starve_d = (starve_q == LIMIT_C) ? LIMIT_C : starve_q + STARVE_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= OWNER_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign bus.out_cpu_rd_valid = (owner_q == OWNER_CPU);
  assign bus.out_ext_rd_valid = (owner_q == OWNER_EXT);
  assign bus.out_cpu_rd_word  = (owner_q == OWNER_CPU) ? bus.in_dmem_rd_word : '0;
  assign bus.out_ext_rd_word  = (owner_q == OWNER_EXT) ? bus.in_dmem_rd_word : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;

  localparam int AW    = 12;
  localparam int WW    = 16;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW)) bus ();

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW),
    .STARVE_LIMIT(LIMIT), .STARVE_CNT_WIDTH(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [WW-1:0] init_word(input int a);
    if (a == 'h010) return 16'hBEEF;
    return 16'((a * 40503) ^ 16'h5A5A);
  endfunction

  // Environment memory: 1-cycle registered read, driven only by the DUT's outputs.
  logic [WW-1:0] env_mem [0:(1<<AW)-1];
  logic [WW-1:0] env_rd;
  bit            env_ready = 1'b0;
  always @(posedge clock) begin
    if (!env_ready) begin
      for (int i = 0; i < (1<<AW); i++) env_mem[i] <= init_word(i);
      env_ready <= 1'b1;
    end else if (bus.out_dmem_en) begin
      if (bus.out_dmem_we) env_mem[bus.out_dmem_addr] <= bus.out_dmem_wr_word;
      else                 env_rd <= env_mem[bus.out_dmem_addr];
    end
  end
  assign bus.in_dmem_rd_word = env_rd;

  // Reference model state
  logic [WW-1:0] model_mem [0:(1<<AW)-1];
  int            ext_lost;
  int            pend_who;          // 0 none, 1 cpu, 2 ext
  logic [WW-1:0] pend_word;
  bit            last_win;

  int total = 0;
  int bad   = 0;

  logic          o_en, o_we, o_gnt, o_stall, o_cv, o_ev;
  logic [AW-1:0] o_addr;
  logic [WW-1:0] o_wdata, o_cw, o_ew;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    o_en = bus.out_dmem_en;   o_we = bus.out_dmem_we;
    o_addr = bus.out_dmem_addr; o_wdata = bus.out_dmem_wr_word;
    o_gnt = bus.out_ext_gnt;  o_stall = bus.out_cpu_stall;
    o_cv = bus.out_cpu_rd_valid; o_cw = bus.out_cpu_rd_word;
    o_ev = bus.out_ext_rd_valid; o_ew = bus.out_ext_rd_word;
  endtask

  // One clock cycle: drive just after posedge, check at negedge, advance the model.
  task automatic do_cycle(input bit crd, input bit cwr, input logic [AW-1:0] ca,
                          input logic [WW-1:0] cd, input bit ereq, input bit ewe,
                          input logic [AW-1:0] ea, input logic [WW-1:0] ed);
    bit cact, win, exp_en, exp_we;
    logic [AW-1:0] exp_a;
    logic [WW-1:0] exp_d;
    bus.in_cpu_rd_en = crd; bus.in_cpu_wr_en = cwr;
    bus.in_cpu_addr  = ca;  bus.in_cpu_wr_word = cd;
    bus.in_ext_req   = ereq; bus.in_ext_we = ewe;
    bus.in_ext_addr  = ea;  bus.in_ext_wr_word = ed;
    #4;
    sample();
    cact   = crd | cwr;
    win    = ereq && (!cact || ext_lost >= LIMIT);
    exp_en = cact | win;
    exp_we = win ? ewe : (cact ? cwr : 1'b0);
    exp_a  = win ? ea : (cact ? ca : '0);
    exp_d  = win ? ed : cd;
    chk("dmem_en", 32'(o_en), 32'(exp_en));
    chk("dmem_we", 32'(o_we), 32'(exp_we));
    chk("dmem_addr", 32'(o_addr), 32'(exp_a));
    if (exp_we)       chk("dmem_wdata", 32'(o_wdata), 32'(exp_d));
    else if (!exp_en) chk("dmem_wdata_idle", 32'(o_wdata), 32'h0);
    chk("ext_gnt", 32'(o_gnt), 32'(win));
    chk("cpu_stall", 32'(o_stall), 32'(cact & win));
    chk("cpu_rd_valid", 32'(o_cv), 32'(pend_who == 1));
    chk("cpu_rd_word", 32'(o_cw), (pend_who == 1) ? 32'(pend_word) : 32'h0);
    chk("ext_rd_valid", 32'(o_ev), 32'(pend_who == 2));
    chk("ext_rd_word", 32'(o_ew), (pend_who == 2) ? 32'(pend_word) : 32'h0);
    pend_who = 0;
    if (win) begin
      if (ewe) model_mem[ea] = ed;
      else begin pend_who = 2; pend_word = model_mem[ea]; end
    end else if (cact) begin
      if (cwr) model_mem[ca] = cd;
      else begin pend_who = 1; pend_word = model_mem[ca]; end
    end
    ext_lost = (ereq && !win) ? ext_lost + 1 : 0;
    last_win = win;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    do_cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  bit            r_req, r_we;
  logic [AW-1:0] r_ea;
  logic [WW-1:0] r_ed;

  initial begin
    for (int i = 0; i < (1<<AW); i++) model_mem[i] = init_word(i);
    ext_lost = 0; pend_who = 0; pend_word = '0; last_win = 0;
    bus.in_cpu_rd_en = 0; bus.in_cpu_wr_en = 0; bus.in_cpu_addr = '0; bus.in_cpu_wr_word = '0;
    bus.in_ext_req = 0; bus.in_ext_we = 0; bus.in_ext_addr = '0; bus.in_ext_wr_word = '0;

    #2;
    sample();
    chk("rst_cpu_valid", 32'(o_cv), 32'h0);
    chk("rst_cpu_word", 32'(o_cw), 32'h0);
    chk("rst_ext_valid", 32'(o_ev), 32'h0);
    chk("rst_ext_word", 32'(o_ew), 32'h0);
    chk("rst_dmem_en", 32'(o_en), 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // CPU read of 0x010
    do_cycle(1, 0, 12'h010, '0, 0, 0, '0, '0);
    chk("cpurd_en", 32'(o_en), 32'h1);
    chk("cpurd_we", 32'(o_we), 32'h0);
    idle();
    chk("cpurd_valid", 32'(o_cv), 32'h1);
    chk("cpurd_word", 32'(o_cw), 32'hBEEF);
    chk("cpurd_ext_valid", 32'(o_ev), 32'h0);

    // CPU stores every cycle while ext holds a request: ext wins on the fifth cycle
    for (int c = 0; c < 6; c++) begin
      do_cycle(0, 1, 12'h040, 16'(c + 16'h0A00), (c <= 4), 0, 12'h050, '0);
      chk($sformatf("starve_gnt_c%0d", c), 32'(o_gnt), 32'(c == 4));
      chk($sformatf("starve_stall_c%0d", c), 32'(o_stall), 32'(c == 4));
    end

    // Ext read of 0x020 with CPU idle
    do_cycle(0, 0, '0, '0, 1, 0, 12'h020, '0);
    chk("extrd_gnt", 32'(o_gnt), 32'h1);
    idle();
    chk("extrd_valid", 32'(o_ev), 32'h1);
    chk("extrd_word", 32'(o_ew), 32'(init_word('h020)));
    chk("extrd_cpu_valid", 32'(o_cv), 32'h0);

    // rd_en and wr_en together is a write
    do_cycle(1, 1, 12'h030, 16'h1234, 0, 0, '0, '0);
    chk("rdwr_we", 32'(o_we), 32'h1);
    chk("rdwr_wdata", 32'(o_wdata), 32'h1234);
    do_cycle(1, 0, 12'h030, '0, 0, 0, '0, '0);
    chk("rdwr_no_valid", 32'(o_cv), 32'h0);
    idle();
    chk("rdwr_readback", 32'(o_cw), 32'h1234);

    // Alternating owners
    do_cycle(1, 0, 12'h001, '0, 0, 0, '0, '0);
    do_cycle(0, 0, '0, '0, 1, 0, 12'h002, '0);
    chk("alt_cpu_valid", 32'(o_cv), 32'h1);
    chk("alt_cpu_word", 32'(o_cw), 32'(init_word(1)));
    idle();
    chk("alt_ext_valid", 32'(o_ev), 32'h1);
    chk("alt_ext_word", 32'(o_ew), 32'(init_word(2)));

    // Read followed by a write still returns the read data
    do_cycle(1, 0, 12'h003, '0, 0, 0, '0, '0);
    do_cycle(0, 1, 12'h003, 16'hCAFE, 0, 0, '0, '0);
    chk("rdwr_seq_word", 32'(o_cw), 32'(init_word(3)));
    do_cycle(1, 0, 12'h003, '0, 0, 0, '0, '0);
    idle();
    chk("rdwr_seq_new", 32'(o_cw), 32'hCAFE);

    // Reset in the cycle after a CPU read drops the pending data
    do_cycle(1, 0, 12'h010, '0, 0, 0, '0, '0);
    bus.in_cpu_rd_en = 0;
    reset = 1'b1;
    #4;
    sample();
    chk("midrst_valid", 32'(o_cv), 32'h0);
    chk("midrst_word", 32'(o_cw), 32'h0);
    pend_who = 0; ext_lost = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      do_cycle(0, 1, 12'h041, 16'h0, 1, 1, 12'h051, 16'h7777);
      chk($sformatf("postrst_gnt_c%0d", c), 32'(o_gnt), 32'(c == 4));
    end

    // Random traffic; ext holds its request until granted, occasionally withdrawing
    r_req = 0; r_we = 0; r_ea = '0; r_ed = '0;
    for (int n = 0; n < 400; n++) begin
      bit crd, cwr;
      if (!r_req && $urandom_range(0, 2) == 0) begin
        r_req = 1; r_we = 1'($urandom_range(0, 1));
        r_ea = AW'($urandom_range(0, 15)); r_ed = WW'($urandom);
      end else if (r_req && $urandom_range(0, 15) == 0) begin
        r_req = 0;
      end
      crd = ($urandom_range(0, 3) != 0);
      cwr = ($urandom_range(0, 2) == 0);
      do_cycle(crd, cwr, AW'($urandom_range(0, 15)), WW'($urandom), r_req, r_we, r_ea, r_ed);
      if (last_win) r_req = 0;
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
